// File: rtl/segment_decode_if.sv
// Segment capture bus: two raw segment patterns in, decoded digit pair out
// over a valid/ready handshake.
interface segment_decode_if;
  logic [8:0] segment_led_1;
  logic [8:0] segment_led_2;
  logic [3:0] seg_data_1;
  logic [3:0] seg_data_2;
  logic       err_1;
  logic       err_2;
  logic       data_valid;
  logic       data_ready;

  modport master (
    input  segment_led_1, segment_led_2, data_ready,
    output seg_data_1, seg_data_2, err_1, err_2, data_valid
  );

  modport slave (
    output segment_led_1, segment_led_2, data_ready,
    input  seg_data_1, seg_data_2, err_1, err_2, data_valid
  );
endinterface

// File: rtl/segment_decode.sv
// Glitch-filtered seven-segment to BCD decoder for two channels, presenting
// the latest stable digit pair over a valid/ready handshake.
module segment_decode #(
  parameter int STABLE_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  segment_decode_if.master bus
);

  localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

  // Returns {digit, err}.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3f:   decode = {4'd0, 1'b0};
      7'h06:   decode = {4'd1, 1'b0};
      7'h5b:   decode = {4'd2, 1'b0};
      7'h4f:   decode = {4'd3, 1'b0};
      7'h66:   decode = {4'd4, 1'b0};
      7'h6d:   decode = {4'd5, 1'b0};
      7'h7d:   decode = {4'd6, 1'b0};
      7'h07:   decode = {4'd7, 1'b0};
      7'h7f:   decode = {4'd8, 1'b0};
      7'h6f:   decode = {4'd9, 1'b0};
      default: decode = {4'hf, 1'b1};
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c >= CNT_SAT) ? CNT_SAT : c + 8'd1;
  endfunction

  logic [6:0] in_s [2];
  logic       unused_hi;

  assign in_s[0]   = bus.segment_led_1[6:0];
  assign in_s[1]   = bus.segment_led_2[6:0];
  assign unused_hi = ^{bus.segment_led_1[8:7], bus.segment_led_2[8:7]};

  logic [6:0] p_q   [2];
  logic [6:0] p_d   [2];
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic [4:0] com_q [2];
  logic [4:0] com_d [2];
  logic [9:0] out_q, out_d;
  logic       vld_q, vld_d;
  logic [9:0] pair_s;

  assign pair_s = {com_q[0], com_q[1]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      p_d[i]   = in_s[i];
      cnt_d[i] = 8'd1;
      com_d[i] = com_q[i];
      if (in_s[i] == p_q[i]) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
        // Saturated counter never equals CNT_COMMIT again, so one commit per pattern.
        if (cnt_q[i] == CNT_COMMIT) com_d[i] = decode(in_s[i]);
      end
    end

    out_d = out_q;
    vld_d = vld_q;
    if ((pair_s != out_q) && (!vld_q || bus.data_ready)) begin
      out_d = pair_s;
      vld_d = 1'b1;
    end else if (vld_q && bus.data_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        p_q[i]   <= 7'h00;
        cnt_q[i] <= 8'd0;
        com_q[i] <= 5'd0;
      end
      out_q <= 10'd0;
      vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        p_q[i]   <= p_d[i];
        cnt_q[i] <= cnt_d[i];
        com_q[i] <= com_d[i];
      end
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.seg_data_1 = out_q[9:6];
  assign bus.err_1      = out_q[5];
  assign bus.seg_data_2 = out_q[4:1];
  assign bus.err_2      = out_q[0];
  assign bus.data_valid = vld_q;

endmodule

// File: tb/tb_segment_decode.sv
// Directed bench for segment_decode with STABLE_CYCLES=4: table of decode
// vectors plus hand-written glitch, stall, bit-ignore and reset sequences.
module tb_segment_decode;

  localparam int SC = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  segment_decode_if bus ();

  segment_decode #(.STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] s1;
    logic [8:0] s2;
    logic [9:0] exp;  // {digit_1, err_1, digit_2, err_2}
  } vec_t;

  vec_t vecs [9];

  function automatic logic [9:0] pair_now();
    return {bus.seg_data_1, bus.err_1, bus.seg_data_2, bus.err_2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int edges);
    edges = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      edges++;
      if (bus.data_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: data_valid never rose within %0d edges", name, edges);
    edges = 999;
  endtask

  initial begin
    int   edges;
    int   pulses;
    int   frozen_ok;
    logic [3:0] seen_d1;

    errors = 0;
    checks = 0;

    vecs[0] = '{9'h05b, 9'h05b, {4'd2, 1'b0, 4'd2, 1'b0}};
    vecs[1] = '{9'h03f, 9'h006, {4'd0, 1'b0, 4'd1, 1'b0}};
    vecs[2] = '{9'h04f, 9'h066, {4'd3, 1'b0, 4'd4, 1'b0}};
    vecs[3] = '{9'h06d, 9'h07d, {4'd5, 1'b0, 4'd6, 1'b0}};
    vecs[4] = '{9'h007, 9'h07f, {4'd7, 1'b0, 4'd8, 1'b0}};
    vecs[5] = '{9'h06f, 9'h03f, {4'd9, 1'b0, 4'd0, 1'b0}};
    vecs[6] = '{9'h049, 9'h03f, {4'hf, 1'b1, 4'd0, 1'b0}};
    vecs[7] = '{9'h17f, 9'h000, {4'd8, 1'b0, 4'hf, 1'b1}};
    vecs[8] = '{9'h006, 9'h006, {4'd1, 1'b0, 4'd1, 1'b0}};

    // Reset with blank inputs
    rst = 1'b1;
    bus.segment_led_1 = 9'h000;
    bus.segment_led_2 = 9'h000;
    bus.data_ready = 1'b1;
    step();
    step();
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_pair", 32'(pair_now()), 32'd0);

    // Blank held after reset commits F/err
    rst = 1'b0;
    wait_valid("blank", edges);
    check("blank_latency", edges, 32'(SC + 1));
    check("blank_pair", 32'(pair_now()), 32'(10'b1111_1_1111_1));
    step();
    check("blank_single_pulse", 32'(bus.data_valid), 32'd0);

    foreach (vecs[i]) begin
      bus.segment_led_1 = vecs[i].s1;
      bus.segment_led_2 = vecs[i].s2;
      wait_valid($sformatf("vec%0d", i), edges);
      check($sformatf("vec%0d_latency", i), edges, 32'(SC + 1));
      check($sformatf("vec%0d_pair", i), 32'(pair_now()), 32'(vecs[i].exp));
      step();
      check($sformatf("vec%0d_pulse_end", i), 32'(bus.data_valid), 32'd0);
    end

    // Glitch of 3 edges must not reach the outputs
    bus.segment_led_1 = 9'h07f;
    step(); step(); step();
    bus.segment_led_1 = 9'h006;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.data_valid) pulses++;
    end
    check("glitch_no_valid", pulses, 0);
    check("glitch_pair", 32'(pair_now()), 32'({4'd1, 1'b0, 4'd1, 1'b0}));

    // Stall: outputs frozen, only latest value delivered on release
    bus.data_ready = 1'b0;
    bus.segment_led_1 = 9'h04f;
    wait_valid("stall_first", edges);
    check("stall_first_pair", 32'(pair_now()), 32'({4'd3, 1'b0, 4'd1, 1'b0}));
    frozen_ok = 1;
    bus.segment_led_1 = 9'h066;
    for (int k = 0; k < 6; k++) begin
      step();
      if (!bus.data_valid || pair_now() != {4'd3, 1'b0, 4'd1, 1'b0}) frozen_ok = 0;
    end
    bus.segment_led_1 = 9'h06d;
    for (int k = 0; k < 6; k++) begin
      step();
      if (!bus.data_valid || pair_now() != {4'd3, 1'b0, 4'd1, 1'b0}) frozen_ok = 0;
    end
    check("stall_frozen", frozen_ok, 1);
    bus.data_ready = 1'b1;
    step();
    check("stall_release_valid", 32'(bus.data_valid), 32'd1);
    check("stall_release_pair", 32'(pair_now()), 32'({4'd5, 1'b0, 4'd1, 1'b0}));
    step();
    check("stall_drain_valid", 32'(bus.data_valid), 32'd0);

    // Bits [8:7] toggling must not restart the filter
    pulses = 0;
    seen_d1 = 4'h0;
    for (int k = 0; k < 12; k++) begin
      bus.segment_led_1 = {2'(k), 7'h6f};
      step();
      if (bus.data_valid) begin
        pulses++;
        seen_d1 = bus.seg_data_1;
      end
    end
    check("hibits_pulses", pulses, 1);
    check("hibits_digit", 32'(seen_d1), 32'd9);

    // Asynchronous reset while data_valid is held
    bus.data_ready = 1'b0;
    bus.segment_led_1 = 9'h007;
    wait_valid("areset_pre", edges);
    check("areset_pre_pair", 32'(pair_now()), 32'({4'd7, 1'b0, 4'd1, 1'b0}));
    #2;
    rst = 1'b1;
    #1;
    check("areset_valid", 32'(bus.data_valid), 32'd0);
    check("areset_pair", 32'(pair_now()), 32'd0);
    step();
    rst = 1'b0;
    bus.data_ready = 1'b1;
    wait_valid("areset_post", edges);
    check("areset_post_latency", edges, 32'(SC + 1));
    check("areset_post_pair", 32'(pair_now()), 32'({4'd7, 1'b0, 4'd1, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
